// File: rtl/alarm_sequencer.sv
// Sequential back end for the S/M/W alarm equation: input synchronisers,
// debounce/alarm FSM, blinking siren and saturating alarm-event counter.
module alarm_sequencer #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned BLINK    = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S,
  input  logic             M,
  input  logic             W,
  input  logic             ack,
  output logic             alarm,
  output logic             siren,
  output logic             armed,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] event_count
);

  localparam int unsigned QW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned BW = (BLINK > 1) ? $clog2(BLINK) : 1;
  localparam logic [QW-1:0]    QMAX = QW'(DEBOUNCE - 1);
  localparam logic [BW-1:0]    BMAX = BW'(BLINK - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMED    = 2'b01,
    QUALIFY  = 2'b10,
    ALARM    = 2'b11
  } state_t;

  logic S_m, M_m, W_m, ack_m;
  logic S_s, M_s, W_s, ack_s;
  logic detect;

  state_t           state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             siren_q, siren_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {S_m, M_m, W_m, ack_m} <= '0;
      {S_s, M_s, W_s, ack_s} <= '0;
    end else begin
      {S_m, M_m, W_m, ack_m} <= {S, M, W, ack};
      {S_s, M_s, W_s, ack_s} <= {S_m, M_m, W_m, ack_m};
    end
  end

  assign detect = S_s & (~W_s | M_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISARMED;
      qcnt_q  <= '0;
      bcnt_q  <= '0;
      siren_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      bcnt_q  <= bcnt_d;
      siren_q <= siren_d;
      count_q <= count_d;
    end
  end

  // siren_d defaults low so every exit from ALARM (including disarm) clears it.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    bcnt_d  = bcnt_q;
    siren_d = 1'b0;
    count_d = count_q;
    if (!S_s) begin
      state_d = DISARMED;
    end else begin
      case (state_q)
        DISARMED: state_d = ARMED;
        ARMED: begin
          if (detect) begin
            state_d = QUALIFY;
            qcnt_d  = '0;
          end
        end
        QUALIFY: begin
          if (!detect) begin
            state_d = ARMED;
          end else if (qcnt_q == QMAX) begin
            state_d = ALARM;
            siren_d = 1'b1;
            bcnt_d  = '0;
            if (count_q != CMAX) count_d = count_q + 1'b1;
          end else begin
            qcnt_d = qcnt_q + 1'b1;
          end
        end
        ALARM: begin
          if (ack_s && !detect) begin
            state_d = ARMED;
          end else if (bcnt_q == BMAX) begin
            siren_d = ~siren_q;
            bcnt_d  = '0;
          end else begin
            siren_d = siren_q;
            bcnt_d  = bcnt_q + 1'b1;
          end
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  assign state       = state_q;
  assign alarm       = (state_q == ALARM);
  assign armed       = (state_q != DISARMED);
  assign siren       = siren_q;
  assign event_count = count_q;

endmodule
